// File: rtl/bus_master_cycle.sv
// bus_master_cycle
// CPU-side bus initiator for ROM/RAM tristate responders. Takes one read or
// write request at a time and sequences cs_/oe_/we_ through
// SETUP -> ACCESS (wait states) -> HOLD (writes only) -> TURN -> IDLE.
// Every output is a flop, so the strobes cannot glitch. The asynchronous
// reset releases the bus immediately, whatever the state.

module bus_master_cycle #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 2,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              cs_,
    output logic              oe_,
    output logic              we_,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_dout_en,
    input  logic [DATA_W-1:0] bus_din
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    // The wait counter is reused for the turnaround count. TURN stays for
    // TURNAROUND cycles, so its exit test (count == 0) needs TURNAROUND-1
    // loaded on entry.
    localparam logic [3:0] RD_LOAD   = 4'(RD_WAIT);
    localparam logic [3:0] WR_LOAD   = 4'(WR_WAIT);
    localparam logic       HAS_TURN  = (TURNAROUND > 0);
    localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam state_t     EXIT_ST   = (TURNAROUND > 0) ? ST_TURN : ST_IDLE;

    state_t     state_r;
    logic       is_write_r;
    logic [3:0] cnt_r;

    // Cycle sequencer. Each output register is loaded with the value that
    // belongs to the state being entered, so the strobe timing follows the
    // state with no combinational decode after the flops.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r     <= ST_IDLE;
            is_write_r  <= 1'b0;
            cnt_r       <= 4'd0;
            ready       <= 1'b1;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_addr    <= '0;
            bus_dout    <= '0;
            cs_         <= 1'b1;
            oe_         <= 1'b1;
            we_         <= 1'b1;
            bus_dout_en <= 1'b0;
        end else begin
            // rdata_valid is a one-cycle pulse; only read completion sets it
            rdata_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // ready is high throughout IDLE, so req alone means accept
                    if (req) begin
                        bus_addr    <= addr;
                        bus_dout    <= wdata;
                        is_write_r  <= we;
                        ready       <= 1'b0;
                        cs_         <= 1'b0;
                        oe_         <= 1'b1;
                        we_         <= 1'b1;
                        bus_dout_en <= we;
                        state_r     <= ST_SETUP;
                    end else begin
                        ready       <= 1'b1;
                        cs_         <= 1'b1;
                        oe_         <= 1'b1;
                        we_         <= 1'b1;
                        bus_dout_en <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // Address and chip select have settled; open the data strobe
                    cnt_r       <= is_write_r ? WR_LOAD : RD_LOAD;
                    cs_         <= 1'b0;
                    oe_         <= is_write_r;
                    we_         <= ~is_write_r;
                    bus_dout_en <= is_write_r;
                    state_r     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        if (is_write_r) begin
                            // Raise we_ first and keep driving the data for one more cycle
                            cs_         <= 1'b0;
                            oe_         <= 1'b1;
                            we_         <= 1'b1;
                            bus_dout_en <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            rdata       <= bus_din;
                            rdata_valid <= 1'b1;
                            cs_         <= 1'b1;
                            oe_         <= 1'b1;
                            we_         <= 1'b1;
                            bus_dout_en <= 1'b0;
                            cnt_r       <= TURN_LOAD;
                            ready       <= ~HAS_TURN;
                            state_r     <= EXIT_ST;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_HOLD: begin
                    // Write finished: release the bus, then idle or turn around
                    cs_         <= 1'b1;
                    oe_         <= 1'b1;
                    we_         <= 1'b1;
                    bus_dout_en <= 1'b0;
                    cnt_r       <= TURN_LOAD;
                    ready       <= ~HAS_TURN;
                    state_r     <= EXIT_ST;
                end
                ST_TURN: begin
                    // Keep all strobes high so the previous responder can release the bus
                    cs_         <= 1'b1;
                    oe_         <= 1'b1;
                    we_         <= 1'b1;
                    bus_dout_en <= 1'b0;
                    if (cnt_r == 4'd0) begin
                        ready   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: return to a safe idle with the bus released
                    cs_         <= 1'b1;
                    oe_         <= 1'b1;
                    we_         <= 1'b1;
                    bus_dout_en <= 1'b0;
                    ready       <= 1'b1;
                    cnt_r       <= 4'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_cycle.sv
// Directed testbench for bus_master_cycle. Instance A uses RD_WAIT=2,
// WR_WAIT=2, TURNAROUND=1. Instance B uses zero wait states and no
// turnaround. A small ROM model drives bus_din from bus_addr while oe_ is low.
// On every falling clock edge the bench checks both instances for bus
// contention and for correct strobe nesting.

module tb_bus_master_cycle;

    logic        clk;
    logic        rst_;
    logic        req_a;
    logic        req_b;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic        ready_a, rdata_valid_a, cs_a, oe_a, we_a, dout_en_a;
    logic [7:0]  rdata_a, bus_dout_a, bus_din_a;
    logic [15:0] bus_addr_a;
    logic        ready_b, rdata_valid_b, cs_b, oe_b, we_b, dout_en_b;
    logic [7:0]  rdata_b, bus_dout_b, bus_din_b;
    logic [15:0] bus_addr_b;

    int n_checks = 0;
    int n_errors = 0;

    // Contents of the ROM model seen by the responder.
    function automatic logic [7:0] rom_data(input logic [15:0] a);
        case (a)
            16'h1234: rom_data = 8'hA5;
            16'h0001: rom_data = 8'h11;
            16'h0002: rom_data = 8'h22;
            default:  rom_data = 8'hEE;
        endcase
    endfunction

    assign bus_din_a = oe_a ? 8'hFF : rom_data(bus_addr_a);
    assign bus_din_b = oe_b ? 8'hFF : rom_data(bus_addr_b);

    bus_master_cycle #(.ADDR_W(16), .DATA_W(8), .RD_WAIT(2), .WR_WAIT(2), .TURNAROUND(1)) dut_a (
        .clk(clk), .rst_(rst_), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_a), .rdata(rdata_a), .rdata_valid(rdata_valid_a),
        .bus_addr(bus_addr_a), .cs_(cs_a), .oe_(oe_a), .we_(we_a),
        .bus_dout(bus_dout_a), .bus_dout_en(dout_en_a), .bus_din(bus_din_a)
    );

    bus_master_cycle #(.ADDR_W(16), .DATA_W(8), .RD_WAIT(0), .WR_WAIT(0), .TURNAROUND(0)) dut_b (
        .clk(clk), .rst_(rst_), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_b), .rdata(rdata_b), .rdata_valid(rdata_valid_b),
        .bus_addr(bus_addr_b), .cs_(cs_b), .oe_(oe_b), .we_(we_b),
        .bus_dout(bus_dout_b), .bus_dout_en(dout_en_b), .bus_din(bus_din_b)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check both instances for contention and strobe nesting on every falling edge
    always @(negedge clk) begin
        if (rst_) begin
            check_val("inv_a", {29'd0, (dout_en_a & ~oe_a), (~oe_a & ~we_a), (cs_a & (~oe_a | ~we_a))}, 32'd0);
            check_val("inv_b", {29'd0, (dout_en_b & ~oe_b), (~oe_b & ~we_b), (cs_b & (~oe_b | ~we_b))}, 32'd0);
        end
    end

    initial begin
        int we_low;
        int den_high;
        int rise_k;
        int fall2_k;
        int n_valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic prev_cs;

        rst_  = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        we    = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;

        // ---------------- reset state ----------------
        step();
        step();
        check_val("rst_ready", {31'd0, ready_a}, 32'd1);
        check_val("rst_cs", {31'd0, cs_a}, 32'd1);
        check_val("rst_oe", {31'd0, oe_a}, 32'd1);
        check_val("rst_we", {31'd0, we_a}, 32'd1);
        check_val("rst_den", {31'd0, dout_en_a}, 32'd0);
        check_val("rst_addr", {16'd0, bus_addr_a}, 32'd0);
        check_val("rst_rdata", {24'd0, rdata_a}, 32'd0);
        check_val("rst_valid", {31'd0, rdata_valid_a}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        step();

        // ---------------- read 0x1234 with RD_WAIT=2, TURNAROUND=1 ----------------
        req_a = 1'b1;
        we    = 1'b0;
        addr  = 16'h1234;
        step();                                   // E0: accepted
        req_a = 1'b0;
        check_val("rd_e0_cs", {31'd0, cs_a}, 32'd0);
        check_val("rd_e0_oe", {31'd0, oe_a}, 32'd1);
        check_val("rd_e0_ready", {31'd0, ready_a}, 32'd0);
        step();                                   // E1: ACCESS
        check_val("rd_e1_oe", {31'd0, oe_a}, 32'd0);
        // Request activity during ACCESS must be ignored
        req_a = 1'b1;
        we    = 1'b1;
        addr  = 16'hFFFF;
        wdata = 8'h99;
        step();                                   // E2
        check_val("rd_e2_addr", {16'd0, bus_addr_a}, 32'h1234);
        check_val("rd_e2_oe", {31'd0, oe_a}, 32'd0);
        req_a = 1'b0;
        we    = 1'b0;
        step();                                   // E3
        check_val("rd_e3_valid", {31'd0, rdata_valid_a}, 32'd0);
        check_val("rd_e3_we", {31'd0, we_a}, 32'd1);
        step();                                   // E4: sample
        check_val("rd_e4_rdata", {24'd0, rdata_a}, 32'h0000_00A5);
        check_val("rd_e4_valid", {31'd0, rdata_valid_a}, 32'd1);
        check_val("rd_e4_cs", {31'd0, cs_a}, 32'd1);
        check_val("rd_e4_oe", {31'd0, oe_a}, 32'd1);
        check_val("rd_e4_ready", {31'd0, ready_a}, 32'd0);
        step();                                   // E5: turnaround done
        check_val("rd_e5_ready", {31'd0, ready_a}, 32'd1);
        check_val("rd_e5_valid", {31'd0, rdata_valid_a}, 32'd0);
        step();
        check_val("rd_no_extra_cs", {31'd0, cs_a}, 32'd1);
        check_val("rd_no_extra_addr", {16'd0, bus_addr_a}, 32'h1234);

        // ---------------- write 0x3C to 0x0040, WR_WAIT=2 ----------------
        req_a  = 1'b1;
        we     = 1'b1;
        addr   = 16'h0040;
        wdata  = 8'h3C;
        step();                                   // E0
        req_a  = 1'b0;
        we_low   = 0;
        den_high = 0;
        for (int i = 0; i < 8; i++) begin
            if (!we_a) we_low++;
            if (dout_en_a) begin
                den_high++;
                check_val("wr_dout", {24'd0, bus_dout_a}, 32'h0000_003C);
                check_val("wr_addr", {16'd0, bus_addr_a}, 32'h0040);
            end
            check_val("wr_oe_high", {31'd0, oe_a}, 32'd1);
            step();
        end
        check_val("wr_we_width", we_low, 32'd3);
        check_val("wr_den_width", den_high, 32'd5);
        check_val("wr_rdata_kept", {24'd0, rdata_a}, 32'h0000_00A5);
        check_val("wr_ready", {31'd0, ready_a}, 32'd1);

        // ---------------- back-to-back reads with req held ----------------
        req_a = 1'b1;
        we    = 1'b0;
        addr  = 16'h0001;
        step();                                   // k=0: first accept
        addr    = 16'h0002;
        rise_k  = -1;
        fall2_k = -1;
        n_valid = 0;
        d0      = 8'h00;
        d1      = 8'h00;
        prev_cs = cs_a;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (prev_cs == 1'b0 && cs_a == 1'b1 && rise_k < 0) rise_k = k;
            if (prev_cs == 1'b1 && cs_a == 1'b0 && rise_k >= 0 && fall2_k < 0) begin
                fall2_k = k;
                req_a   = 1'b0;
            end
            if (rdata_valid_a) begin
                if (n_valid == 0) d0 = rdata_a;
                else d1 = rdata_a;
                n_valid++;
            end
            prev_cs = cs_a;
        end
        req_a = 1'b0;
        check_val("b2b_rise", rise_k, 32'd4);
        check_val("b2b_gap", fall2_k - rise_k, 32'd2);
        check_val("b2b_pulses", n_valid, 32'd2);
        check_val("b2b_data0", {24'd0, d0}, 32'h0000_0011);
        check_val("b2b_data1", {24'd0, d1}, 32'h0000_0022);

        // ---------------- reset in the middle of a write's ACCESS ----------------
        req_a = 1'b1;
        we    = 1'b1;
        addr  = 16'h0080;
        wdata = 8'h5A;
        step();                                   // E0
        req_a = 1'b0;
        step();                                   // E1
        step();                                   // E2: ACCESS
        check_val("mid_we_low", {31'd0, we_a}, 32'd0);
        #2;
        rst_ = 1'b0;                              // between clock edges
        #1;
        check_val("arst_cs", {31'd0, cs_a}, 32'd1);
        check_val("arst_we", {31'd0, we_a}, 32'd1);
        check_val("arst_den", {31'd0, dout_en_a}, 32'd0);
        check_val("arst_ready", {31'd0, ready_a}, 32'd1);
        check_val("arst_valid", {31'd0, rdata_valid_a}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("post_rst_valid", {31'd0, rdata_valid_a}, 32'd0);
            check_val("post_rst_cs", {31'd0, cs_a}, 32'd1);
        end
        check_val("post_rst_ready", {31'd0, ready_a}, 32'd1);

        // ---------------- zero wait, zero turnaround read on instance B ----------------
        req_b = 1'b1;
        we    = 1'b0;
        addr  = 16'h0002;
        step();                                   // E0
        req_b = 1'b0;
        check_val("z_e0_cs", {31'd0, cs_b}, 32'd0);
        check_val("z_e0_ready", {31'd0, ready_b}, 32'd0);
        step();                                   // E1: single ACCESS cycle
        check_val("z_e1_oe", {31'd0, oe_b}, 32'd0);
        check_val("z_e1_ready", {31'd0, ready_b}, 32'd0);
        step();                                   // E2: sample and back to IDLE
        check_val("z_e2_oe", {31'd0, oe_b}, 32'd1);
        check_val("z_e2_rdata", {24'd0, rdata_b}, 32'h0000_0022);
        check_val("z_e2_valid", {31'd0, rdata_valid_b}, 32'd1);
        check_val("z_e2_ready", {31'd0, ready_b}, 32'd1);
        check_val("z_e2_cs", {31'd0, cs_b}, 32'd1);
        step();
        check_val("z_e3_valid", {31'd0, rdata_valid_b}, 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
